// File: rtl/seg_scanner.sv
// -----------------------------------------------------------------------------
// seg_scanner
//
// Multiplexed 7-segment display scanner with double-buffered data, leading-zero
// blanking, per-slot dead time and PWM brightness control.
//
// Parameters
//   DIGITS     number of multiplexed digits (1..8)
//   DIV        clk cycles per digit slot (>= 2)
//   DUTY_BITS  brightness resolution in bits (1..8)
//
// Ports
//   clk         single clock, all state updates on its rising edge
//   rst         synchronous active-high reset
//   data_in     hex nibbles, nibble k drives digit k (digit 0 least significant)
//   dp_in       decimal-point request per digit, active-high
//   load        captures data_in/dp_in into the shadow register
//   blank_lz    enables leading-zero blanking (sampled live, not shadowed)
//   bright      brightness, 0 = dark, all-ones = fully on
//   anode       digit enables, active-low, registered
//   seg         segments {g,f,e,d,c,b,a}, active-low, registered
//   dp          decimal point, active-low, registered
//   frame_done  one-cycle pulse after each full scan
// -----------------------------------------------------------------------------
module seg_scanner #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DIV       = 100000,
    parameter int unsigned DUTY_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*DIGITS-1:0]    data_in,
    input  logic [DIGITS-1:0]      dp_in,
    input  logic                   load,
    input  logic                   blank_lz,
    input  logic [DUTY_BITS-1:0]   bright,
    output logic [DIGITS-1:0]      anode,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic                   frame_done
);

    localparam int unsigned PW = $clog2(DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DUTY_BITS-1:0]   pwm_q, pwm_d;

    logic [4*DIGITS-1:0]    shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]      shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0]    disp_data_q, disp_data_d;
    logic [DIGITS-1:0]      disp_dp_q, disp_dp_d;

    logic [DIGITS-1:0]      anode_q, anode_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic                   frame_done_q, frame_done_d;

    // -------------------------------------------------------------------------
    // Hex to active-low segment decode, bit order {g,f,e,d,c,b,a}
    // -------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Timebase: slot prescaler, digit index, PWM counter
    // -------------------------------------------------------------------------
    logic tick;
    logic frame_end;

    always_comb begin
        tick      = (pcnt_q == PCNT_MAX);
        frame_end = tick && (idx_q == IDX_MAX);

        pcnt_d = tick ? '0 : pcnt_q + PW'(1);

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end

        pwm_d = pwm_q + DUTY_BITS'(1);
    end

    // -------------------------------------------------------------------------
    // Double buffer. The display copy happens only on the frame boundary so a
    // frame is never drawn from two different values. A load landing on the
    // boundary writes the shadow on the same edge the display reads it, so the
    // display gets the previous shadow and the new value waits one frame.
    // -------------------------------------------------------------------------
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        if (load) begin
            shadow_data_d = data_in;
            shadow_dp_d   = dp_in;
        end

        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        if (frame_end) begin
            disp_data_d = shadow_data_q;
            disp_dp_d   = shadow_dp_q;
        end
    end

    // -------------------------------------------------------------------------
    // Leading-zero detection: upper_zero[k] is set when nibble k and every
    // more-significant nibble of the display register are zero.
    // -------------------------------------------------------------------------
    logic [DIGITS-1:0] upper_zero;

    always_comb begin
        upper_zero = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (k == DIGITS - 1) begin
                upper_zero[k] = (disp_data_q[4*k +: 4] == 4'h0);
            end else begin
                upper_zero[k] = (disp_data_q[4*k +: 4] == 4'h0) && upper_zero[k+1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output stage. Everything is derived from the current pcnt/idx/pwm and
    // display state and registered, giving one cycle of latency.
    // -------------------------------------------------------------------------
    logic       slot_on;
    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       cur_blank;

    always_comb begin
        // pcnt == 0 is the dead cycle between slots; all-ones bright bypasses
        // the compare so full brightness has no off cycles.
        slot_on = (pcnt_q != '0) &&
                  ((pwm_q < bright) || (bright == {DUTY_BITS{1'b1}}));

        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        anode_d   = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib    = disp_data_q[4*k +: 4];
                cur_dp     = disp_dp_q[k];
                // Digit 0 always shows, so a zero value still reads "0".
                cur_blank  = blank_lz && (k != 0) && upper_zero[k];
                anode_d[k] = ~slot_on;
            end
        end

        seg_d        = cur_blank ? SEG_OFF : hex_to_seg(cur_nib);
        dp_d         = ~cur_dp;
        frame_done_d = frame_end;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q        <= '0;
            idx_q         <= '0;
            pwm_q         <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            anode_q       <= '1;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            pcnt_q        <= pcnt_d;
            idx_q         <= idx_d;
            pwm_q         <= pwm_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            anode_q       <= anode_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign anode      = anode_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule
